// File: rtl/add4b.sv
// add4b: registered 4-bit carry-lookahead adder with group generate/propagate.
// Optional registered carry-out port Co is built when ADD4B_COUT_EN is defined.
module add4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] ai,
  input  logic [3:0] bi,
  input  logic       C0,
  output logic [3:0] s,
  output logic       GG,
  output logic       GP
`ifdef ADD4B_COUT_EN
  ,
  output logic       Co
`endif
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;
  logic [3:0] sum_d;
  logic       gg_d;
  logic       gp_d;

  assign g = ai & bi;
  assign p = ai ^ bi;

  // Every carry is a flat sum of products of g/p/C0, so no carry waits on another.
  always_comb begin
    c    = 4'b0000;
    c[0] = C0;
    c[1] = g[0] | (p[0] & C0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C0);
  end

  assign sum_d = p ^ c;
  assign gp_d  = &p;
  assign gg_d  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s  <= 4'b0000;
      GG <= 1'b0;
      GP <= 1'b0;
    end else if (en) begin
      s  <= sum_d;
      GG <= gg_d;
      GP <= gp_d;
    end
  end

`ifdef ADD4B_COUT_EN
  logic co_d;

  assign co_d = gg_d | (gp_d & C0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Co <= 1'b0;
    end else if (en) begin
      Co <= co_d;
    end
  end
`endif

endmodule

// File: tb/tb_add4b.sv
// tb_add4b: directed and randomized checks of add4b against an arithmetic model.
// Define ADD4B_COUT_EN for both bench and RTL to also check Co.
module tb_add4b;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] ai;
  logic [3:0] bi;
  logic       c0;
  logic [3:0] s;
  logic       gg;
  logic       gp;
`ifdef ADD4B_COUT_EN
  logic       co;
`endif

  int n_checks;
  int n_fail;

  // {co, gg, gp, s}
  logic [6:0] exp_q[$];
  logic [6:0] model_state;

  add4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .ai    (ai),
    .bi    (bi),
    .C0    (c0),
    .s     (s),
    .GG    (gg),
    .GP    (gp)
`ifdef ADD4B_COUT_EN
    ,
    .Co    (co)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // GP means the operands alone sum to exactly 15; GG means they overflow by themselves.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b, input logic c);
    int sum_ab;
    int total;
    sum_ab = int'(a) + int'(b);
    total  = sum_ab + int'(c);
    model  = {total > 15, sum_ab > 15, sum_ab == 15, 4'(total % 16)};
  endfunction

  // driver: apply inputs, advance one edge, update model, check outputs #1 later
  task automatic drive_cycle(input logic r, input logic e, input logic [3:0] a,
                             input logic [3:0] b, input logic c);
    logic [6:0] exp;
    rst_n = r;
    en    = e;
    ai    = a;
    bi    = b;
    c0    = c;
    if (!r) model_state = 7'd0;
    else if (e) model_state = model(a, b, c);
    exp_q.push_back(model_state);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("s", 32'(s), 32'(exp[3:0]));
    check("gp", 32'(gp), 32'(exp[4]));
    check("gg", 32'(gg), 32'(exp[5]));
    check("gg_gp_excl", 32'(gg & gp), 32'd0);
`ifdef ADD4B_COUT_EN
    check("co", 32'(co), 32'(exp[6]));
`endif
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_state = 7'd0;
    rst_n = 1'b0;
    en    = 1'b0;
    ai    = 4'd0;
    bi    = 4'd0;
    c0    = 1'b0;
    @(negedge clk);

    // reset with busy inputs
    drive_cycle(1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    drive_cycle(1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_gg", 32'(gg), 32'd0);

    // generate
    drive_cycle(1'b1, 1'b1, 4'd15, 4'd1, 1'b0);
    check("gen_s", 32'(s), 32'd0);
    check("gen_gg", 32'(gg), 32'd1);
    check("gen_gp", 32'(gp), 32'd0);
`ifdef ADD4B_COUT_EN
    check("gen_co", 32'(co), 32'd1);
`endif

    // propagate, without and with carry-in
    drive_cycle(1'b1, 1'b1, 4'd5, 4'd10, 1'b0);
    check("prop_s", 32'(s), 32'd15);
    check("prop_gp", 32'(gp), 32'd1);
    drive_cycle(1'b1, 1'b1, 4'd5, 4'd10, 1'b1);
    check("prop_c_s", 32'(s), 32'd0);
    check("prop_c_gp", 32'(gp), 32'd1);
    check("prop_c_gg", 32'(gg), 32'd0);
`ifdef ADD4B_COUT_EN
    check("prop_c_co", 32'(co), 32'd1);
`endif

    // hold
    drive_cycle(1'b1, 1'b1, 4'd3, 4'd4, 1'b0);
    check("load_s", 32'(s), 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 4'd9, 4'd9, 1'b0);
      check("hold_s", 32'(s), 32'd7);
      check("hold_gg", 32'(gg), 32'd0);
    end

    // reset wins over en, then fresh load
    drive_cycle(1'b0, 1'b1, 4'd8, 4'd8, 1'b0);
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_gg", 32'(gg), 32'd0);
    drive_cycle(1'b1, 1'b1, 4'd8, 4'd8, 1'b0);
    check("reload_s", 32'(s), 32'd0);
    check("reload_gg", 32'(gg), 32'd1);

    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          drive_cycle(1'b1, 1'b1, 4'(a), 4'(b), 1'(c));

    // random en / reset traffic
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
